// File: rtl/mips_param_core.sv
// mips_param_core: mini-MIPS execute block; instruction in via in_valid/in_ready (rst_n async low), one out_valid pulse per accepted instruction with instruction_fail and NOUT DW-bit register read-back fields on out_data
module mips_param_core #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int NOUT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instruction,
  input  logic [NOUT*5-1:0]  output_reg,
  output logic               out_valid,
  output logic               instruction_fail,
  output logic [NOUT*DW-1:0] out_data
);
  localparam int AW = $clog2(NREG);
  localparam logic [5:0] NR = 6'(NREG);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [DW-1:0] rf [NREG];
  logic [DW-1:0] rv [32];
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, sh, wi, g_rd;
  logic [DW-1:0] a, b, imm, slt, alu, wv, ga, gb;
  logic [NOUT*5-1:0] oi, g_oi;
  logic [NOUT*DW-1:0] od;
  logic r_type, addi, known, is_gcd, bad, take, gdone, done, ofail, wen;
  assign {op, rs, rt, rd, sh, fn} = instruction;
  for (genvar i = 0; i < 32; i++) begin : g_rv
    if (i < NREG) begin : g_in
      assign rv[i] = rf[i];
    end else begin : g_oor
      assign rv[i] = '0;
    end
  end
  assign a = rv[rs];
  assign b = rv[rt];
  assign imm = DW'($signed(instruction[15:0]));
  assign slt = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
  assign r_type = op == 6'b000000;
  assign addi = op == 6'b001000;
  assign known = fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                            6'b101010, 6'b000000, 6'b000010, 6'b111000};
  assign is_gcd = r_type && fn == 6'b111000;
  assign alu = fn == 6'b100000 ? a + b :
               fn == 6'b100010 ? a - b :
               fn == 6'b100100 ? a & b :
               fn == 6'b100101 ? a | b :
               fn == 6'b100111 ? ~(a | b) :
               fn == 6'b101010 ? slt :
               fn == 6'b000000 ? b << sh :
               fn == 6'b000010 ? b >> sh : '0;
  assign bad = !(addi || (r_type && known)) || {1'b0, rs} >= NR || {1'b0, rt} >= NR ||
               (r_type && {1'b0, rd} >= NR) || (is_gcd && (a == '0 || b == '0));
  assign in_ready = state == IDLE;
  assign take = in_valid && state == IDLE;
  assign gdone = state == BUSY && gb == '0;
  assign done = (take && (bad || !is_gcd)) || gdone;
  assign ofail = state == IDLE && bad;
  assign wen = done && !ofail;
  assign wi = state == BUSY ? g_rd : addi ? rt : rd;
  assign wv = state == BUSY ? ga : addi ? a + imm : alu;
  assign oi = state == BUSY ? g_oi : output_reg;
  assign state_nx = (take && is_gcd && !bad) ? BUSY : gdone ? IDLE : state;
  for (genvar k = 0; k < NOUT; k++) begin : g_o
    logic [4:0] x;
    assign x = oi[5*k +: 5];
    assign od[DW*k +: DW] = ofail ? '0 : (wen && x == wi && x != 5'd0) ? wv : rv[x];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ga <= '0;
      gb <= '0;
      g_rd <= '0;
      g_oi <= '0;
      out_valid <= 1'b0;
      instruction_fail <= 1'b0;
      out_data <= '0;
      for (int j = 0; j < NREG; j++) rf[j] <= '0;
    end else begin
      state <= state_nx;
      out_valid <= done;
      if (done) begin
        instruction_fail <= ofail;
        out_data <= od;
      end
      if (wen && wi != 5'd0) rf[wi[AW-1:0]] <= wv;
      if (take && is_gcd && !bad) begin
        ga <= a;
        gb <= b;
        g_rd <= rd;
        g_oi <= output_reg;
      end else if (state == BUSY && !gdone) begin
        ga <= gb;
        gb <= ga % gb;
      end
    end
  end
endmodule

// File: tb/tb_mips_param_core.sv
// tb_mips_param_core: randomized and directed checks of mips_param_core against an instruction-level reference model
module tb_mips_param_core;
  localparam int DW = 16, NREG = 8, NOUT = 4;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic in_ready, out_valid, instruction_fail;
  logic [31:0] instruction = '0;
  logic [NOUT*5-1:0] output_reg = '0;
  logic [NOUT*DW-1:0] out_data;
  int total = 0, bad = 0;
  logic [DW-1:0] mr [32];

  always #5 clk = ~clk;

  mips_param_core #(.DW(DW), .NREG(NREG), .NOUT(NOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .output_reg(output_reg), .out_valid(out_valid),
    .instruction_fail(instruction_fail), .out_data(out_data)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] rt_ins(int fn, int rs, int rt, int rd, int sh);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] ai_ins(int rs, int rt, int imm);
    return {6'b001000, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] rand_ins();
    int fns [9] = '{32, 34, 36, 37, 39, 42, 0, 2, 56};
    int k = int'($urandom_range(0, 19));
    int rs = int'($urandom_range(0, 8));
    int rt = int'($urandom_range(0, 8));
    int rd = int'($urandom_range(0, 8));
    if (k < 7) return ai_ins(rs, rt, int'($urandom));
    if (k == 18) return rt_ins(3, rs, rt, rd, 0);
    if (k == 19) return {6'b000100, 26'($urandom)};
    return rt_ins(fns[$urandom_range(0, 8)], rs, rt, rd, int'($urandom_range(0, 31)));
  endfunction

  function automatic logic [NOUT*5-1:0] rand_orr();
    logic [NOUT*5-1:0] r;
    for (int k = 0; k < NOUT; k++) r[5*k +: 5] = 5'($urandom_range(0, 9));
    return r;
  endfunction

  // Architectural model: executes a whole instruction at once, then reports the
  // expected read-back, the fail flag and the number of extra cycles a GCD spends
  // (one per Euclid step plus the final step that sees a zero remainder).
  function automatic void model_exec(input logic [31:0] ins, input logic [NOUT*5-1:0] orr,
                                     output logic f, output logic [NOUT*DW-1:0] od, output int lat);
    int op = int'(ins[31:26]);
    int rs = int'(ins[25:21]);
    int rt = int'(ins[20:16]);
    int rd = int'(ins[15:11]);
    int sh = int'(ins[10:6]);
    int fn = int'(ins[5:0]);
    int wr = 0;
    logic [DW-1:0] va, vb, res, x, y, t;
    va = rs < NREG ? mr[rs] : '0;
    vb = rt < NREG ? mr[rt] : '0;
    f = 1'b0;
    lat = 0;
    res = '0;
    if (rs >= NREG || rt >= NREG) f = 1'b1;
    else if (op == 8) begin
      res = va + ins[15:0];
      wr = rt;
    end else if (op != 0 || rd >= NREG) f = 1'b1;
    else begin
      wr = rd;
      case (fn)
        32: res = va + vb;
        34: res = va - vb;
        36: res = va & vb;
        37: res = va | vb;
        39: res = ~(va | vb);
        42: res = {15'd0, ($signed(va) < $signed(vb))};
        0: res = sh >= DW ? '0 : vb << sh;
        2: res = sh >= DW ? '0 : vb >> sh;
        56: begin
          if (va == '0 || vb == '0) f = 1'b1;
          else begin
            x = va;
            y = vb;
            lat = 1;
            while (y != '0) begin
              t = x % y;
              x = y;
              y = t;
              lat++;
            end
            res = x;
          end
        end
        default: f = 1'b1;
      endcase
    end
    if (!f && wr != 0) mr[wr] = res;
    od = '0;
    for (int k = 0; k < NOUT; k++) begin
      int i = int'(orr[5*k +: 5]);
      if (!f && i < NREG) od[DW*k +: DW] = mr[i];
    end
  endfunction

  // Drives one instruction from a negedge, returns what the DUT reported on its
  // result pulse, the cycles between transfer and pulse (-1 on timeout), and
  // out_valid one cycle after the pulse.
  task automatic run(input logic [31:0] ins, input logic [NOUT*5-1:0] orr, output logic of,
                     output logic [NOUT*DW-1:0] od, output int lat, output logic ov_after);
    int n = 0;
    instruction = ins;
    output_reg = orr;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    lat = out_valid ? n : -1;
    of = instruction_fail;
    od = out_data;
    @(negedge clk);
    ov_after = out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) mr[i] = '0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (instruction_fail !== 1'b0) begin bad++; $display("FAIL reset_fail got=%b exp=0", instruction_fail); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [3];
    logic [NOUT*5-1:0] orr = {5'd0, 5'd3, 5'd2, 5'd1};
    logic ef;
    logic [NOUT*DW-1:0] eo;
    int lat;
    prog[0] = ai_ins(0, 1, 5);
    prog[1] = ai_ins(0, 2, -3);
    prog[2] = rt_ins(32, 1, 2, 3, 0);
    output_reg = orr;
    for (int i = 0; i < 3; i++) begin
      instruction = prog[i];
      in_valid = 1'b1;
      model_exec(prog[i], orr, ef, eo, lat);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, in_ready); end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || instruction_fail !== ef || out_data !== eo) begin
        bad++;
        $display("FAIL b2b_result[%0d] got v=%b f=%b d=%h exp v=1 f=%b d=%h", i, out_valid, instruction_fail, out_data, ef, eo);
      end
    end
    in_valid = 1'b0;
    total++; if (out_data !== 64'h0000_0002_FFFD_0005) begin bad++; $display("FAIL b2b_add got=%h exp=0000_0002_fffd_0005", out_data); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_pulse got=%b exp=0", out_valid); end
  endtask

  task automatic test_alu();
    logic [31:0] prog [3];
    logic [NOUT*5-1:0] orr = {5'd1, 5'd6, 5'd5, 5'd4};
    logic ef, of, ova;
    logic [NOUT*DW-1:0] eo, od;
    int lat, n;
    prog[0] = rt_ins(34, 0, 1, 4, 0);
    prog[1] = rt_ins(42, 4, 1, 5, 0);
    prog[2] = rt_ins(0, 0, 1, 6, 17);
    for (int i = 0; i < 3; i++) begin
      model_exec(prog[i], orr, ef, eo, lat);
      run(prog[i], orr, of, od, n, ova);
      total++;
      if (n !== 0 || of !== 1'b0 || od !== eo) begin
        bad++;
        $display("FAIL alu_step[%0d] got lat=%0d f=%b d=%h exp lat=0 f=0 d=%h", i, n, of, od, eo);
      end
    end
    total++; if (od !== 64'h0005_0000_0001_FFFB) begin bad++; $display("FAIL alu_sub_slt_sll got=%h exp=0005_0000_0001_fffb", od); end
  endtask

  task automatic test_gcd();
    logic [31:0] g = rt_ins(56, 1, 2, 3, 0);
    logic [NOUT*5-1:0] orr = {5'd0, 5'd2, 5'd1, 5'd3};
    logic ef, of, ova;
    logic [NOUT*DW-1:0] eo, od;
    int lat, n, busy_bad;
    model_exec(ai_ins(0, 1, 12), '0, ef, eo, lat);
    run(ai_ins(0, 1, 12), '0, of, od, n, ova);
    model_exec(ai_ins(0, 2, 8), '0, ef, eo, lat);
    run(ai_ins(0, 2, 8), '0, of, od, n, ova);
    model_exec(g, orr, ef, eo, lat);
    instruction = g;
    output_reg = orr;
    in_valid = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL gcd_accept got=%b exp=1", in_ready); end
    @(negedge clk);
    instruction = ai_ins(0, 5, 99);
    n = 0;
    busy_bad = 0;
    while (!out_valid && n < 100) begin
      if (in_ready !== 1'b0) busy_bad++;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    total++; if (n !== 3) begin bad++; $display("FAIL gcd_latency got=%0d exp=3", n); end
    total++; if (busy_bad !== 0) begin bad++; $display("FAIL gcd_in_ready_busy got=%0d exp=0", busy_bad); end
    total++; if (out_data !== 64'h0000_0008_000C_0004) begin bad++; $display("FAIL gcd_result got=%h exp=0000_0008_000c_0004", out_data); end
    total++; if (instruction_fail !== 1'b0) begin bad++; $display("FAIL gcd_fail got=%b exp=0", instruction_fail); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gcd_dropped got=%b exp=0", out_valid); end
    model_exec(rt_ins(32, 0, 0, 0, 0), {5'd0, 5'd0, 5'd5, 5'd3}, ef, eo, lat);
    run(rt_ins(32, 0, 0, 0, 0), {5'd0, 5'd0, 5'd5, 5'd3}, of, od, n, ova);
    total++; if (od !== eo) begin bad++; $display("FAIL gcd_readback got=%h exp=%h", od, eo); end
  endtask

  task automatic test_gcd_zero();
    logic ef, of, ova;
    logic [NOUT*DW-1:0] eo, od;
    int lat, n;
    model_exec(ai_ins(0, 2, 0), '0, ef, eo, lat);
    run(ai_ins(0, 2, 0), '0, of, od, n, ova);
    model_exec(rt_ins(56, 1, 2, 3, 0), {5'd3, 5'd3, 5'd1, 5'd3}, ef, eo, lat);
    run(rt_ins(56, 1, 2, 3, 0), {5'd3, 5'd3, 5'd1, 5'd3}, of, od, n, ova);
    total++; if (n !== 0) begin bad++; $display("FAIL gcdz_latency got=%0d exp=0", n); end
    total++; if (of !== 1'b1) begin bad++; $display("FAIL gcdz_fail got=%b exp=1", of); end
    total++; if (od !== '0) begin bad++; $display("FAIL gcdz_data got=%h exp=0", od); end
    total++; if (ova !== 1'b0) begin bad++; $display("FAIL gcdz_pulse got=%b exp=0", ova); end
    model_exec(rt_ins(32, 0, 0, 0, 0), {5'd0, 5'd2, 5'd1, 5'd3}, ef, eo, lat);
    run(rt_ins(32, 0, 0, 0, 0), {5'd0, 5'd2, 5'd1, 5'd3}, of, od, n, ova);
    total++; if (od !== 64'h0000_0000_000C_0004) begin bad++; $display("FAIL gcdz_unchanged got=%h exp=0000_0000_000c_0004", od); end
  endtask

  task automatic test_invalid();
    logic [31:0] prog [3];
    logic [NOUT*5-1:0] orr = {5'd3, 5'd2, 5'd1, 5'd7};
    logic ef, of, ova;
    logic [NOUT*DW-1:0] eo, od;
    int lat, n;
    prog[0] = rt_ins(32, 1, 1, 9, 0);
    prog[1] = {6'b000100, 5'd1, 5'd7, 16'h0004};
    prog[2] = rt_ins(3, 1, 2, 7, 0);
    for (int i = 0; i < 3; i++) begin
      model_exec(prog[i], orr, ef, eo, lat);
      run(prog[i], orr, of, od, n, ova);
      total++;
      if (n !== 0 || of !== 1'b1 || od !== '0) begin
        bad++;
        $display("FAIL invalid[%0d] got lat=%0d f=%b d=%h exp lat=0 f=1 d=0", i, n, of, od);
      end
    end
    model_exec(ai_ins(0, 0, 7), '0, ef, eo, lat);
    run(ai_ins(0, 0, 7), '0, of, od, n, ova);
    total++; if (of !== 1'b0 || od !== '0) begin bad++; $display("FAIL addi_r0 got f=%b d=%h exp f=0 d=0", of, od); end
    model_exec(rt_ins(32, 0, 0, 0, 0), orr, ef, eo, lat);
    run(rt_ins(32, 0, 0, 0, 0), orr, of, od, n, ova);
    total++; if (od !== eo) begin bad++; $display("FAIL invalid_no_write got=%h exp=%h", od, eo); end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [NOUT*5-1:0] orr;
    logic ef, of, ova;
    logic [NOUT*DW-1:0] eo, od;
    int lat, n;
    for (int i = 0; i < 120; i++) begin
      ins = rand_ins();
      orr = rand_orr();
      model_exec(ins, orr, ef, eo, lat);
      run(ins, orr, of, od, n, ova);
      total++; if (n !== lat) begin bad++; $display("FAIL rand_latency[%0d] ins=%h got=%0d exp=%0d", i, ins, n, lat); end
      total++; if (of !== ef) begin bad++; $display("FAIL rand_fail[%0d] ins=%h got=%b exp=%b", i, ins, of, ef); end
      total++; if (od !== eo) begin bad++; $display("FAIL rand_data[%0d] ins=%h got=%h exp=%h", i, ins, od, eo); end
      total++; if (ova !== 1'b0) begin bad++; $display("FAIL rand_pulse[%0d] got=%b exp=0", i, ova); end
    end
  endtask

  task automatic test_reset_mid_gcd();
    logic ef, of, ova;
    logic [NOUT*DW-1:0] eo, od;
    int lat, n;
    model_exec(ai_ins(0, 1, 12), '0, ef, eo, lat);
    run(ai_ins(0, 1, 12), '0, of, od, n, ova);
    model_exec(ai_ins(0, 2, 8), {15'd0, 5'd2}, ef, eo, lat);
    run(ai_ins(0, 2, 8), {15'd0, 5'd2}, of, od, n, ova);
    instruction = rt_ins(56, 1, 2, 3, 0);
    output_reg = {5'd3, 5'd3, 5'd3, 5'd3};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstg_busy got=%b exp=0", in_ready); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstg_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rstg_out_data got=%h exp=0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstg_in_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 32; i++) mr[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL rstg_no_result got=%0d exp=0", n); end
    run(rt_ins(32, 0, 0, 0, 0), {5'd4, 5'd3, 5'd2, 5'd1}, of, od, n, ova);
    total++; if (n !== 0 || of !== 1'b0 || od !== '0) begin bad++; $display("FAIL rstg_regs got lat=%0d f=%b d=%h exp lat=0 f=0 d=0", n, of, od); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_alu();
    test_gcd();
    test_gcd_zero();
    test_invalid();
    test_random();
    test_reset_mid_gcd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
